// File: rtl/spi_data_recv.sv
// SPI mode-0 slave receiver: oversamples SCK/SS/MOSI in the clk domain, deserialises
// DATA_W-bit MSB-first frames and presents good words with a valid/read handshake.
// Optional build macro: SPI_RX_TIMEOUT_EN aborts a frame whose SCK stalls for TIMEOUT_CYC clocks.
module spi_data_recv #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  input  logic              data_rd,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DATA_W < 2) begin : g_bad_width
    $error("DATA_W must be at least 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Synchroniser chains; the top bit of sck/ss is the extra flop used for edge detection.
  logic [SYNC_STAGES:0]   sck_sr;
  logic [SYNC_STAGES:0]   ss_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic sck_rise, ss_fall, ss_rise, mosi_s;

  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic clear_en, shift_en, load_word, err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sr  <= '0;
      // NOTE: SS resets to the asserted level so that a frame already in progress when reset
      // releases produces no ss_fall; a spurious ss_rise in IDLE is harmless.
      ss_sr   <= '0;
      mosi_sr <= '0;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-1:0], spi_clk};
      ss_sr   <= {ss_sr[SYNC_STAGES-1:0], spi_ss};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sck_rise = sck_sr[SYNC_STAGES-1] & ~sck_sr[SYNC_STAGES];
  assign ss_fall  = ~ss_sr[SYNC_STAGES-1] & ss_sr[SYNC_STAGES];
  assign ss_rise  = ss_sr[SYNC_STAGES-1] & ~ss_sr[SYNC_STAGES];
  assign mosi_s   = mosi_sr[SYNC_STAGES-1];

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts clocks of SCK silence inside a frame; any SCK rise or leaving SHIFT restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != ST_SHIFT || sck_rise) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    state_nxt = state;
    clear_en  = 1'b0;
    shift_en  = 1'b0;
    load_word = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          state_nxt = ST_SHIFT;
          clear_en  = 1'b1;
        end
      end
      ST_SHIFT: begin
        // A rise coinciding with ss_rise is still shifted and counted before DONE.
        shift_en = sck_rise;
        if (ss_rise) begin
          state_nxt = ST_DONE;
        end
`ifdef SPI_RX_TIMEOUT_EN
        else if (!sck_rise && tmo_cnt == TMO_LAST) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        if (bit_cnt == CNT_FULL) begin
          load_word = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (clear_en) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[DATA_W-2:0], mosi_s};
      if (bit_cnt != CNT_SAT) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= err_nxt;
      if (load_word) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
        // A read in the same cycle consumes the old word, so nothing is lost.
        if (data_valid && !data_rd) begin
          overrun <= 1'b1;
        end
      end else if (data_rd) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule
